reorder_buffer: RTL and testbench

In-order retirement tracker placed directly downstream of register rename. It accepts up to two renamed instructions per cycle and assigns each a ROB tag. It takes up to three out-of-order completion reports per cycle and retires up to two completed instructions per cycle in program order. Each retirement returns the previous physical destination register to the rename free pool.

---
 rtl/reorder_buffer.sv | 149 ++++++++++++++
 tb/tb_reorder_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement tracker: 2-wide dispatch, 3 completion ports, 2-wide retire.
// Optional macro ROB_COMPLETE_BYPASS_EN lets a same-cycle completion retire the head entries directly.
package reorder_buffer_pkg;
    typedef logic [6:0] p_reg;

    typedef struct packed {
        p_reg PRegAddrDst;
        p_reg OldPRegAddrDst;
        logic RegWrite;
    } rename_struct;
endpackage

module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dispatch_valid        [0:1],
    input  rename_struct     i_rename_data           [0:1],
    output logic             o_dispatch_ready,
    output logic [TAG_W-1:0] o_rob_tag               [0:1],
    input  logic             i_complete_valid        [0:2],
    input  logic [TAG_W-1:0] i_complete_tag          [0:2],
    output logic             o_retire_valid          [0:1],
    output p_reg             o_retire_PRegAddrDst    [0:1],
    output p_reg             o_retire_OldPRegAddrDst [0:1],
    output logic             o_free_valid            [0:1],
    output logic [TAG_W:0]   o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam logic [TAG_W:0] READY_MAX = (TAG_W+1)'(DEPTH - 2);
    localparam logic [TAG_W:0] FULL_CNT  = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head_q, tail_q, head1, tail1;
    logic [TAG_W-1:0] head_d, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, done_q, valid_d, done_d;
    logic [DEPTH-1:0] comp_hit, done_eff;
    p_reg             pdst_q [DEPTH];
    p_reg             old_q  [DEPTH];
    logic             acc0, acc1, r0, r1;

    assign head1   = head_q + TAG_W'(1);
    assign tail1   = tail_q + TAG_W'(1);
    assign o_count = count_q;
    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == FULL_CNT);

    always_comb begin
        // Ready looks at the pre-retire count, so it is conservative by one cycle when full.
        o_dispatch_ready = !i_rst && (count_q <= READY_MAX);
        acc0 = o_dispatch_ready && i_dispatch_valid[0];
        acc1 = o_dispatch_ready && i_dispatch_valid[1];
        o_rob_tag[0] = tail_q;
        o_rob_tag[1] = i_dispatch_valid[0] ? tail1 : tail_q;

        comp_hit = '0;
        for (int p = 0; p < 3; p++) begin
            if (i_complete_valid[p]) comp_hit[i_complete_tag[p]] = 1'b1;
        end

`ifdef ROB_COMPLETE_BYPASS_EN
        done_eff = done_q | comp_hit;
`else
        done_eff = done_q;
`endif

        r0 = valid_q[head_q] && done_eff[head_q];
        r1 = r0 && valid_q[head1] && done_eff[head1];

        // Completion first, then retire clears, then dispatch; the order matters only for a bypassed head.
        valid_d = valid_q;
        done_d  = done_q | (comp_hit & valid_q);
        if (r0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (r1) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
        end
        if (acc0) begin
            valid_d[o_rob_tag[0]] = 1'b1;
            done_d[o_rob_tag[0]]  = 1'b0;
        end
        if (acc1) begin
            valid_d[o_rob_tag[1]] = 1'b1;
            done_d[o_rob_tag[1]]  = 1'b0;
        end

        head_d  = head_q + TAG_W'(r0) + TAG_W'(r1);
        tail_d  = tail_q + TAG_W'(acc0) + TAG_W'(acc1);
        count_d = count_q + (TAG_W+1)'(acc0) + (TAG_W+1)'(acc1)
                          - (TAG_W+1)'(r0) - (TAG_W+1)'(r1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            for (int l = 0; l < 2; l++) begin
                o_retire_valid[l]          <= 1'b0;
                o_free_valid[l]            <= 1'b0;
                o_retire_PRegAddrDst[l]    <= '0;
                o_retire_OldPRegAddrDst[l] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;

            o_retire_valid[0] <= r0;
            o_retire_valid[1] <= r1;
            o_free_valid[0]   <= r0 && (old_q[head_q] != '0);
            o_free_valid[1]   <= r1 && (old_q[head1] != '0);
            if (r0) begin
                o_retire_PRegAddrDst[0]    <= pdst_q[head_q];
                o_retire_OldPRegAddrDst[0] <= old_q[head_q];
            end
            if (r1) begin
                o_retire_PRegAddrDst[1]    <= pdst_q[head1];
                o_retire_OldPRegAddrDst[1] <= old_q[head1];
            end
        end
    end

    // Entry payload; an instruction without a destination never frees a register.
    always_ff @(posedge i_clk) begin
        if (acc0) begin
            pdst_q[o_rob_tag[0]] <= i_rename_data[0].PRegAddrDst;
            old_q[o_rob_tag[0]]  <= i_rename_data[0].RegWrite ? i_rename_data[0].OldPRegAddrDst : '0;
        end
        if (acc1) begin
            pdst_q[o_rob_tag[1]] <= i_rename_data[1].PRegAddrDst;
            old_q[o_rob_tag[1]]  <= i_rename_data[1].RegWrite ? i_rename_data[1].OldPRegAddrDst : '0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus hand sequences for full, wrap and reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             dv [0:1];
    rename_struct     rd [0:1];
    logic             rdy;
    logic [TAG_W-1:0] tag [0:1];
    logic             cv [0:2];
    logic [TAG_W-1:0] ct [0:2];
    logic             rv [0:1];
    p_reg             rdst [0:1];
    p_reg             rold [0:1];
    logic             fv [0:1];
    logic [TAG_W:0]   cnt;
    logic             empty, full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_dispatch_valid(dv), .i_rename_data(rd),
        .o_dispatch_ready(rdy), .o_rob_tag(tag),
        .i_complete_valid(cv), .i_complete_tag(ct),
        .o_retire_valid(rv), .o_retire_PRegAddrDst(rdst),
        .o_retire_OldPRegAddrDst(rold), .o_free_valid(fv),
        .o_count(cnt), .o_empty(empty), .o_full(full)
    );

    typedef struct {
        logic       rst;
        logic [1:0] dv;
        int         d0, o0, d1, o1;
        logic [2:0] cv;
        int         c0, c1, c2;
        logic       e_rdy;
        int         e_t0, e_t1;
        logic [1:0] e_rv, e_fv;
        int         e_rd0, e_ro0, e_rd1, e_ro1, e_cnt;
    } vec_t;

    vec_t vecs [19];
    int   retired [$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] d, input int d0, input int o0,
                         input int d1, input int o1, input logic [2:0] c,
                         input int c0, input int c1, input int c2);
        rst   = r;
        dv[0] = d[0];
        dv[1] = d[1];
        rd[0] = '{p_reg'(d0), p_reg'(o0), (o0 != 0)};
        rd[1] = '{p_reg'(d1), p_reg'(o1), (o1 != 0)};
        cv[0] = c[0];
        cv[1] = c[1];
        cv[2] = c[2];
        ct[0] = TAG_W'(c0);
        ct[1] = TAG_W'(c1);
        ct[2] = TAG_W'(c2);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect();
        for (int l = 0; l < 2; l++) begin
            if (rv[l]) retired.push_back(int'(rdst[l]));
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        drive(v.rst, v.dv, v.d0, v.o0, v.d1, v.o1, v.cv, v.c0, v.c1, v.c2);
        #1;
        chk($sformatf("v%0d ready", i), int'(rdy), int'(v.e_rdy));
        if (!v.rst) begin
            chk($sformatf("v%0d tag0", i), int'(tag[0]), v.e_t0);
            chk($sformatf("v%0d tag1", i), int'(tag[1]), v.e_t1);
        end
        tick();
        chk($sformatf("v%0d retire_valid0", i), int'(rv[0]), int'(v.e_rv[0]));
        chk($sformatf("v%0d retire_valid1", i), int'(rv[1]), int'(v.e_rv[1]));
        chk($sformatf("v%0d free_valid0", i), int'(fv[0]), int'(v.e_fv[0]));
        chk($sformatf("v%0d free_valid1", i), int'(fv[1]), int'(v.e_fv[1]));
        chk($sformatf("v%0d count", i), int'(cnt), v.e_cnt);
        if (v.e_rv[0]) begin
            chk($sformatf("v%0d retire_dst0", i), int'(rdst[0]), v.e_rd0);
            chk($sformatf("v%0d retire_old0", i), int'(rold[0]), v.e_ro0);
        end
        if (v.e_rv[1]) begin
            chk($sformatf("v%0d retire_dst1", i), int'(rdst[1]), v.e_rd1);
            chk($sformatf("v%0d retire_old1", i), int'(rold[1]), v.e_ro1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst dv     d0 o0 d1 o1 cv      c0 c1 c2 rdy t0 t1 rv     fv     rd0 ro0 rd1 ro1 cnt
        vecs[0]  = '{1, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00,  0, 0,  0, 0, 0};
        vecs[1]  = '{0, 2'b11, 32, 1,33, 2, 3'b000, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00,  0, 0,  0, 0, 2};
        vecs[2]  = '{0, 2'b00,  0, 0, 0, 0, 3'b001, 1, 0, 0, 1,  2, 2, 2'b00, 2'b00,  0, 0,  0, 0, 2};
        vecs[3]  = '{0, 2'b00,  0, 0, 0, 0, 3'b001, 0, 0, 0, 1,  2, 2, 2'b00, 2'b00,  0, 0,  0, 0, 2};
        vecs[4]  = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  2, 2, 2'b11, 2'b11, 32, 1, 33, 2, 0};
        vecs[5]  = '{0, 2'b11, 40, 3,41, 4, 3'b000, 0, 0, 0, 1,  2, 3, 2'b00, 2'b00,  0, 0,  0, 0, 2};
        vecs[6]  = '{0, 2'b01, 42, 5, 0, 0, 3'b000, 0, 0, 0, 1,  4, 5, 2'b00, 2'b00,  0, 0,  0, 0, 3};
        vecs[7]  = '{0, 2'b10,  0, 0,43, 6, 3'b000, 0, 0, 0, 1,  5, 5, 2'b00, 2'b00,  0, 0,  0, 0, 4};
        vecs[8]  = '{0, 2'b01,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  6, 7, 2'b00, 2'b00,  0, 0,  0, 0, 5};
        vecs[9]  = '{0, 2'b00,  0, 0, 0, 0, 3'b111, 2, 3, 3, 1,  7, 7, 2'b00, 2'b00,  0, 0,  0, 0, 5};
        vecs[10] = '{0, 2'b00,  0, 0, 0, 0, 3'b111, 4, 5, 5, 1,  7, 7, 2'b11, 2'b11, 40, 3, 41, 4, 3};
        vecs[11] = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  7, 7, 2'b11, 2'b11, 42, 5, 43, 6, 1};
        vecs[12] = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  7, 7, 2'b00, 2'b00,  0, 0,  0, 0, 1};
        vecs[13] = '{0, 2'b00,  0, 0, 0, 0, 3'b011, 6, 7, 0, 1,  7, 7, 2'b00, 2'b00,  0, 0,  0, 0, 1};
        vecs[14] = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  7, 7, 2'b01, 2'b00,  0, 0,  0, 0, 0};
        vecs[15] = '{0, 2'b01, 50, 7, 0, 0, 3'b000, 0, 0, 0, 1,  7, 8, 2'b00, 2'b00,  0, 0,  0, 0, 1};
        vecs[16] = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  8, 8, 2'b00, 2'b00,  0, 0,  0, 0, 1};
        vecs[17] = '{0, 2'b00,  0, 0, 0, 0, 3'b001, 7, 0, 0, 1,  8, 8, 2'b00, 2'b00,  0, 0,  0, 0, 1};
        vecs[18] = '{0, 2'b00,  0, 0, 0, 0, 3'b000, 0, 0, 0, 1,  8, 8, 2'b01, 2'b01, 50, 7,  0, 0, 0};

        for (int i = 0; i < 19; i++) apply(vecs[i], i);
        chk("table empty", int'(empty), 1);

        // Fill to DEPTH with dual dispatch, then drain two while full.
        drive(1'b1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 2'b11, 16 + 2*k, 2*k + 1, 17 + 2*k, 2*k + 2, 3'b000, 0, 0, 0);
            #1;
            chk($sformatf("fill%0d ready", k), int'(rdy), 1);
            chk($sformatf("fill%0d tag0", k), int'(tag[0]), 2*k);
            chk($sformatf("fill%0d tag1", k), int'(tag[1]), 2*k + 1);
            tick();
            chk($sformatf("fill%0d count", k), int'(cnt), 2*k + 2);
        end
        chk("full flag", int'(full), 1);
        drive(1'b0, 2'b11, 99, 9, 98, 8, 3'b011, 0, 1, 0);
        #1;
        chk("full ready", int'(rdy), 0);
        tick();
        chk("full dropped count", int'(cnt), 16);
        idle();
        #1;
        chk("full retire-cycle ready", int'(rdy), 0);
        tick();
        chk("full retire0", int'(rv[0]), 1);
        chk("full retire1", int'(rv[1]), 1);
        chk("full retire dst0", int'(rdst[0]), 16);
        chk("full retire dst1", int'(rdst[1]), 17);
        chk("full drained count", int'(cnt), 14);
        chk("full flag cleared", int'(full), 0);
        chk("ready after drain", int'(rdy), 1);
        drive(1'b0, 2'b01, 90, 0, 0, 0, 3'b000, 0, 0, 0);
        tick();
        idle();
        #1;
        chk("count15", int'(cnt), 15);
        chk("ready at 15", int'(rdy), 0);

        // Move head/tail to 14, then dispatch across the wrap point.
        drive(1'b1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        tick();
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 2'b11, 100 + 2*k, 2*k + 1, 101 + 2*k, 2*k + 2,
                  (k > 0) ? 3'b011 : 3'b000, 2*k - 2, 2*k - 1, 0);
            tick();
        end
        drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b011, 12, 13, 0);
        tick();
        idle();
        for (int n = 0; n < 20 && cnt != 0; n++) tick();
        chk("wrap pre-drain count", int'(cnt), 0);
        #1;
        chk("wrap start tag", int'(tag[0]), 14);
        retired.delete();
        drive(1'b0, 2'b11, 74, 15, 75, 16, 3'b000, 0, 0, 0);
        #1;
        chk("wrap tag a", int'(tag[0]), 14);
        chk("wrap tag b", int'(tag[1]), 15);
        tick();
        collect();
        drive(1'b0, 2'b11, 60, 1, 61, 2, 3'b000, 0, 0, 0);
        #1;
        chk("wrap tag c", int'(tag[0]), 0);
        chk("wrap tag d", int'(tag[1]), 1);
        tick();
        collect();
        drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b111, 14, 15, 0);
        tick();
        collect();
        drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b001, 1, 0, 0);
        tick();
        collect();
        idle();
        for (int n = 0; n < 6; n++) begin
            tick();
            collect();
        end
        chk("wrap retire total", retired.size(), 4);
        if (retired.size() == 4) begin
            chk("wrap order 0", retired[0], 74);
            chk("wrap order 1", retired[1], 75);
            chk("wrap order 2", retired[2], 60);
            chk("wrap order 3", retired[3], 61);
        end
        chk("wrap end count", int'(cnt), 0);

        // Mid-stream reset; completions of the discarded tags must not retire anything.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b11, 20 + 2*k, 3 + 2*k, 21 + 2*k, 4 + 2*k, 3'b000, 0, 0, 0);
            tick();
        end
        chk("pre-reset count", int'(cnt), 6);
        drive(1'b1, 2'b11, 30, 5, 31, 6, 3'b111, 2, 3, 4);
        #1;
        chk("reset ready", int'(rdy), 0);
        tick();
        chk("reset count", int'(cnt), 0);
        chk("reset empty", int'(empty), 1);
        chk("reset retire0", int'(rv[0]), 0);
        chk("reset free0", int'(fv[0]), 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b111, 2, 3, 4);
            else if (k == 1) drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b111, 5, 6, 7);
            else idle();
            tick();
            chk($sformatf("stale%0d retire0", k), int'(rv[0]), 0);
            chk($sformatf("stale%0d retire1", k), int'(rv[1]), 0);
            chk($sformatf("stale%0d count", k), int'(cnt), 0);
        end
        chk("stale empty", int'(empty), 1);

        // Minimum completion-to-retire latency.
        drive(1'b0, 2'b01, 70, 9, 0, 0, 3'b000, 0, 0, 0);
        tick();
        drive(1'b0, 2'b00, 0, 0, 0, 0, 3'b001, 0, 0, 0);
        tick();
`ifdef ROB_COMPLETE_BYPASS_EN
        chk("latency C+1 retire", int'(rv[0]), 1);
`else
        chk("latency C+1 retire", int'(rv[0]), 0);
`endif
        idle();
        tick();
`ifdef ROB_COMPLETE_BYPASS_EN
        chk("latency C+2 retire", int'(rv[0]), 0);
`else
        chk("latency C+2 retire", int'(rv[0]), 1);
        chk("latency retire dst", int'(rdst[0]), 70);
`endif
        chk("latency end count", int'(cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
